// File: rtl/pixel_ring_writer.sv
// Write-side controller for the recirculating CRT pixel ring.
// Zero-fills the ring after reset, then decays, refreshes and plots pixels.
module pixel_ring_writer #(
    parameter int DEPTH         = 8192,
    parameter int DECAY_DIV     = 4,
    parameter int DECAY_STEP    = 8,
    parameter int INTENSITY_NEW = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] shiftout,
    output logic [31:0] shiftin,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        clearing,
    output logic [13:0] lit_count
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int LW = 14;

    localparam logic [SW-1:0] SLOT_LAST = SW'(DEPTH - 1);
    localparam logic [RW-1:0] REV_LAST  = RW'(DECAY_DIV - 1);
    localparam logic [7:0]    INT_NEW   = 8'(INTENSITY_NEW);
    localparam logic [8:0]    DEC_STEP  = 9'(DECAY_STEP);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [RW-1:0]   rev_cnt_q, rev_cnt_d;
    logic            hold_valid_q, hold_valid_d;
    logic [9:0]      hold_x_q, hold_x_d;
    logic [9:0]      hold_y_q, hold_y_d;
    logic [LW-1:0]   lit_run_q, lit_run_d;
    logic [LW-1:0]   lit_count_q, lit_count_d;

    logic [9:0]      s_x;
    logic [9:0]      s_y;
    logic [7:0]      s_int;
    logic [8:0]      dec_diff;
    logic [7:0]      dec_int;
    logic            wrap;
    logic            decay_pass;
    logic            consume;
    logic            accept;
    logic            lit_inc;
    logic [LW-1:0]   lit_next;
    logic            unused_rsvd;

    assign s_x   = shiftout[9:0];
    assign s_y   = shiftout[19:10];
    assign s_int = shiftout[27:20];

    // Reserved bits of the incoming word are dropped on rewrite.
    assign unused_rsvd = ^shiftout[31:28];

    assign dec_diff   = {1'b0, s_int} - DEC_STEP;
    assign dec_int    = dec_diff[8] ? 8'd0 : dec_diff[7:0];
    assign wrap       = (slot_cnt_q == SLOT_LAST);
    assign decay_pass = (rev_cnt_q == REV_LAST);
    assign lit_count  = lit_count_q;

    always_comb begin
        state_d      = state_q;
        slot_cnt_d   = slot_cnt_q + SW'(1);
        rev_cnt_d    = rev_cnt_q;
        hold_valid_d = hold_valid_q;
        hold_x_d     = hold_x_q;
        hold_y_d     = hold_y_q;
        lit_run_d    = lit_run_q;
        lit_count_d  = lit_count_q;
        shiftin      = 32'd0;
        consume      = 1'b0;
        accept       = 1'b0;
        pixel_ready  = 1'b0;
        clearing     = 1'b0;
        lit_inc      = 1'b0;
        lit_next     = lit_run_q;

        unique case (state_q)
            S_CLEAR: begin
                clearing = 1'b1;
                if (wrap) begin
                    state_d    = S_RUN;
                    slot_cnt_d = '0;
                    rev_cnt_d  = '0;
                    lit_run_d  = '0;
                end
            end
            S_RUN: begin
                if (hold_valid_q &&
                    (s_int == 8'd0 ||
                     (s_x == hold_x_q && s_y == hold_y_q))) begin
                    shiftin = {4'b0, INT_NEW, hold_y_q, hold_x_q};
                    consume = 1'b1;
                end else if (decay_pass && s_int != 8'd0) begin
                    shiftin = {4'b0, dec_int, s_y, s_x};
                end else begin
                    shiftin = {4'b0, shiftout[27:0]};
                end

                // A consumed hold can be refilled on the same clock.
                pixel_ready = !hold_valid_q || consume;
                accept      = pixel_valid && pixel_ready;
                if (accept) begin
                    hold_valid_d = 1'b1;
                    hold_x_d     = pixel_x;
                    hold_y_d     = pixel_y;
                end else if (consume) begin
                    hold_valid_d = 1'b0;
                end

                lit_inc  = (shiftin[27:20] != 8'd0);
                lit_next = lit_run_q + LW'(lit_inc);
                if (wrap) begin
                    slot_cnt_d  = '0;
                    lit_count_d = lit_next;
                    lit_run_d   = '0;
                    rev_cnt_d   = decay_pass ? '0 : rev_cnt_q + RW'(1);
                end else begin
                    lit_run_d = lit_next;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_CLEAR;
            slot_cnt_q   <= '0;
            rev_cnt_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_x_q     <= '0;
            hold_y_q     <= '0;
            lit_run_q    <= '0;
            lit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            rev_cnt_q    <= rev_cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_x_q     <= hold_x_d;
            hold_y_q     <= hold_y_d;
            lit_run_q    <= lit_run_d;
            lit_count_q  <= lit_count_d;
        end
    end

endmodule
